// File: rtl/bascomp_pkg.sv
// bascomp_pkg: shared encodings and default widths for the basic-computer memory path.
package bascomp_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker; a tie goes to whoever did not own the last grant.
module rr_pick2 import bascomp_pkg::*; (
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic       grant_valid,
    output owner_t     grant_id
);
    assign grant_valid = |req;
    assign grant_id    = owner_t'(&req ? ~last_owner : req[1]);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences CPU and program-loader accesses onto the single-port main memory.
// Optional loader burst lock is built when MEM_ARBITER_LOCK_EN is defined.
module mem_arbiter import bascomp_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic              cpu_wait,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_done,
    output logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] mem_outdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              locked
);
    state_t            state;
    owner_t            owner, last_owner, pick_id;
    logic              we, pick_valid, pick_we, cpu_eligible;
    logic [DATA_W-1:0] rdata_q;
`ifdef MEM_ARBITER_LOCK_EN
    logic lock_cap;
    assign cpu_eligible = cpu_req & ~(locked & ldr_lock);
`else
    logic lock_unused;
    assign lock_unused  = ldr_lock;
    assign cpu_eligible = cpu_req;
`endif
    rr_pick2 u_pick (
        .req        ({ldr_req, cpu_eligible}),
        .last_owner (last_owner),
        .grant_valid(pick_valid),
        .grant_id   (pick_id)
    );
    assign pick_we  = (pick_id == OWN_LDR) ? ldr_we : cpu_we;
    assign cpu_wait = cpu_req & ~cpu_done;
    // memory output is registered, so read data is passed through during the done cycle and held afterwards
    assign rdata    = (state == RESP && !we) ? mem_outdata : rdata_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_LDR;
            we         <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_done   <= 1'b0;
            ldr_done   <= 1'b0;
            rdata_q    <= '0;
            locked     <= 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
            lock_cap   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MEM_ARBITER_LOCK_EN
                    if (locked && !ldr_lock) locked <= 1'b0;
`endif
                    if (pick_valid) begin
                        owner      <= pick_id;
                        last_owner <= pick_id;
                        we         <= pick_we;
                        mem_addr   <= (pick_id == OWN_LDR) ? ldr_addr : cpu_addr;
                        mem_wdata  <= (pick_id == OWN_LDR) ? ldr_wdata : cpu_wdata;
                        mem_read   <= ~pick_we;
                        mem_write  <= pick_we;
`ifdef MEM_ARBITER_LOCK_EN
                        lock_cap   <= (pick_id == OWN_LDR) & ldr_lock;
`endif
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    cpu_done  <= owner == OWN_CPU;
                    ldr_done  <= owner == OWN_LDR;
`ifdef MEM_ARBITER_LOCK_EN
                    if (lock_cap) locked <= 1'b1;
`endif
                    state     <= RESP;
                end
                RESP: begin
                    cpu_done <= 1'b0;
                    ldr_done <= 1'b0;
                    if (!we) rdata_q <= mem_outdata;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus checked against a transaction-level arbiter model.
module tb_mem_arbiter;
    localparam int AW = 12, DW = 16;
`ifdef MEM_ARBITER_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
    logic [AW-1:0] cpu_addr = '0, ldr_addr = '0, mem_addr;
    logic [DW-1:0] cpu_wdata = '0, ldr_wdata = '0, rdata, mem_wdata, mem_outdata;
    logic cpu_done, cpu_wait, ldr_done, mem_read, mem_write, locked;
    logic pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] ref_mem [0:4095];
    int total = 0, bad = 0, cyc = 0;
    bit busy, cwe, lcap, mlocked, e_cd, e_ld;
    int age, who, last;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    int order[$], dcyc[$], exp_o[$];

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_wait(cpu_wait),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_done(ldr_done),
        .rdata(rdata), .mem_outdata(mem_outdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .locked(locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read) mem_outdata <= mem[mem_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One access occupies the memory for a grant cycle, a strobe cycle and a done cycle.
    task automatic model_advance();
        bit c, l;
        if (reset) begin
            busy = 0; age = 0; last = 1; mlocked = 0;
            return;
        end
        if (!busy) begin
            c = cpu_req && !(LOCK && mlocked && ldr_lock);
            l = ldr_req;
            if (mlocked && !ldr_lock) mlocked = 0;
            if (c || l) begin
                who   = (c && l) ? 1 - last : int'(l);
                last  = who;
                busy  = 1;
                age   = 0;
                cwe   = who == 1 ? ldr_we : cpu_we;
                caddr = who == 1 ? ldr_addr : cpu_addr;
                cwd   = who == 1 ? ldr_wdata : cpu_wdata;
                lcap  = who == 1 && ldr_lock;
            end
        end else if (age == 0) begin
            age = 1;
            if (LOCK && lcap) mlocked = 1;
        end else begin
            busy = 0;
            if (cwe) ref_mem[caddr] = cwd;
        end
    endtask

    task automatic check_outputs();
        bit acc, rsp;
        acc  = busy && age == 0;
        rsp  = busy && age == 1;
        e_cd = rsp && who == 0;
        e_ld = rsp && who == 1;
        chk("mem_read", mem_read, acc && !cwe);
        chk("mem_write", mem_write, acc && cwe);
        if (acc) chk("mem_addr", mem_addr, caddr);
        if (acc && cwe) chk("mem_wdata", mem_wdata, cwd);
        chk("cpu_done", cpu_done, e_cd);
        chk("ldr_done", ldr_done, e_ld);
        chk("cpu_wait", cpu_wait, cpu_req && !e_cd);
        chk("locked", locked, mlocked);
        if (rsp && !cwe) chk("rdata", rdata, ref_mem[caddr]);
        if (e_cd || e_ld) begin
            order.push_back(e_ld ? 1 : 0);
            dcyc.push_back(cyc);
        end
    endtask

    task automatic tick();
        model_advance();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1; cpu_req = 0; ldr_req = 0; ldr_lock = 0;
        tick();
        tick();
        reset = 0;
        order.delete();
        dcyc.delete();
        cyc = 0;
    endtask

    task automatic serve(input bit is_ldr, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int lat, output logic [DW-1:0] q);
        lat = -1;
        q = '0;
        if (is_ldr) begin ldr_req = 1; ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_lock = 0; end
        else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (is_ldr ? ldr_done : cpu_done) begin
                lat = k;
                q = rdata;
                break;
            end
        end
        ldr_req = 0;
        cpu_req = 0;
        tick();
        chk(is_ldr ? "ldr_latency" : "cpu_latency", lat, 2);
    endtask

    initial begin
        int lat, n;
        logic [DW-1:0] q;
        reset = 1;
        for (int i = 0; i < 256; i++) begin
            pl_en = 1;
            pl_addr = AW'(i);
            pl_data = (i == 16) ? 16'h7800 : DW'($urandom);
            ref_mem[i] = pl_data;
            tick();
        end
        pl_en = 0;
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // CPU read only
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
        tick();
        chk("t1_strobe", mem_read, 1);
        chk("t1_addr", mem_addr, 12'h010);
        tick();
        chk("t1_done", cpu_done, 1);
        chk("t1_rdata", rdata, 16'h7800);
        chk("t1_ldr_done", ldr_done, 0);
        cpu_req = 0;
        tick();
        tick();

        // loader write then CPU read
        serve(1, 1, 12'h0FF, 16'hA5A5, lat, q);
        serve(0, 0, 12'h0FF, 16'h0000, lat, q);
        chk("t2_rdata", q, 16'hA5A5);

        // simultaneous requests after reset alternate starting with the CPU
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h001;
        ldr_req = 1; ldr_we = 0; ldr_addr = 12'h002;
        while (cyc < 11) tick();
        cpu_req = 0; ldr_req = 0;
        tick();
        tick();
        chk("tie_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            chk($sformatf("tie_owner%0d", i), order[i], i % 2);
            chk($sformatf("tie_cycle%0d", i), dcyc[i], 2 + 3 * i);
        end

        // reset during the strobe cycle of a CPU read
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
        tick();
        reset = 1; cpu_req = 0;
        tick();
        chk("rst_mid_done", cpu_done, 0);
        chk("rst_mid_strobes", {mem_read, mem_write}, 0);
        reset = 0;
        tick();
        serve(0, 0, 12'h010, 16'h0000, lat, q);
        chk("rst_mid_refetch", q, 16'h7800);

        // loader burst with lock request while the CPU keeps asking
        do_reset();
        n = 0;
        ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 12'h000; ldr_wdata = DW'($urandom);
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h020;
        for (int k = 0; k < 80 && (cpu_req || ldr_req); k++) begin
            tick();
            if (ldr_done) begin
                n++;
                if (n < 4) begin ldr_addr = AW'(n); ldr_wdata = DW'($urandom); end
                else begin ldr_req = 0; ldr_lock = 0; end
            end
            if (cpu_done && n >= 4) cpu_req = 0;
        end
        chk("lock_timeout", {cpu_req, ldr_req}, 0);
        cpu_req = 0; ldr_req = 0; ldr_lock = 0;
        tick();
        tick();
        if (LOCK) exp_o = '{1, 1, 1, 1, 0};
        else exp_o = '{1, 0, 1, 0, 1, 0, 1, 0};
        chk("lock_count", order.size(), exp_o.size());
        for (int i = 0; i < exp_o.size() && i < order.size(); i++)
            chk($sformatf("lock_owner%0d", i), order[i], exp_o[i]);

        // random traffic
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if (e_cd) cpu_req = 0;
            if (e_ld) begin ldr_req = 0; ldr_lock = 0; end
            if (k < 1480 && !cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = AW'($urandom_range(0, 31)); cpu_wdata = DW'($urandom);
            end
            if (k < 1480 && !ldr_req && $urandom_range(0, 2) == 0) begin
                ldr_req = 1; ldr_we = 1'($urandom_range(0, 1));
                ldr_addr = AW'($urandom_range(0, 31)); ldr_wdata = DW'($urandom);
                ldr_lock = $urandom_range(0, 3) != 0;
            end
            tick();
        end
        chk("rand_idle", {cpu_req, ldr_req, mem_read, mem_write}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences every access to the single-port main memory (12-bit address, 16-bit words, synchronous read).
- Shares that memory between two requesters:
  - the CPU control path, which uses AR as the address;
  - a program loader fed by the keyboard/io_interface, which writes programs before or while the CPU is halted.
- Sits between the requesters and the memory instance. It owns the memory's read, write, adress and indata pins and hands back the read data with a completion pulse.

Parameters:
- ADDR_W, 12, memory address width (matches AR/PC).
- DATA_W, 16, memory word width (matches bus/DR).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held high until cpu_done.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address (AR).
- cpu_wdata  in  DATA_W  CPU write data (bus).
- cpu_done  out  1  one-cycle completion pulse to the CPU.
- cpu_wait  out  1  cpu_req & ~cpu_done, combinational; freezes the sequence counter.
- ldr_req  in  1  loader access request; held high until ldr_done.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_lock  in  1  loader lock request (only with the optional feature).
- ldr_done  out  1  one-cycle completion pulse to the loader.
- rdata  out  DATA_W  read data, valid in the cycle the matching done pulse is high.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- locked  out  1  loader holds the lock (constant 0 without the feature).

Behaviour:
- State machine states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples both request lines.
  - If neither is high, stays in IDLE.
  - If exactly one is high, grants it.
  - If both are high, grants the requester that did not own the last grant (round robin via the last_owner register).
  - On grant, registers owner, we, addr and wdata, then moves to ACCESS.
- ACCESS (one cycle):
  - Drives mem_addr and mem_wdata from the captured values.
  - Drives mem_read = ~we and mem_write = we.
  - Moves to RESP.
- RESP (one cycle):
  - Strobes are low.
  - For a read, rdata <= mem_outdata (the memory's registered output).
  - The owner's done pulse is high.
  - Moves to IDLE.
- Latency: request seen in IDLE at cycle N -> strobe in N+1 -> done in N+2. Reads and writes both take 3 cycles from IDLE to IDLE.
- Handshake rules:
  - Requesters drop req on the edge where done is sampled high.
  - A req still high in the following IDLE cycle is a new access.
  - Changing addr, we or wdata while req is high and before done is a protocol error; the captured values are used.
  - Only the owner receives done. The other requester keeps waiting and is served in the next IDLE, because round robin guarantees it wins any tie.
- Reset values:
  - State IDLE.
  - mem_read, mem_write, cpu_done, ldr_done and locked are 0.
  - rdata, mem_addr and mem_wdata are 0.
  - last_owner is LDR, so the CPU wins the first tie.
- Reset mid-operation:
  - Any in-flight access is abandoned and no done is issued.
  - A write in ACCESS is cut if reset coincides with that edge; the memory word is then undefined and the bench must not check it.
- mem strobes are never high in IDLE or RESP. At most one strobe is high in any cycle.

Optional Feature:
- Macro: MEM_ARBITER_LOCK_EN.
- With the macro:
  - If ldr_lock = 1 when the loader is granted, locked sets in RESP.
  - While locked = 1, IDLE ignores cpu_req, so a burst load proceeds back to back.
  - locked clears in IDLE when ldr_lock = 0 is sampled; in that same cycle the normal arbitration rules apply.
  - A lock request made while the CPU owns the memory waits for that access to finish.
- Without the macro: ldr_lock is ignored and locked is tied to 0.

Decomposition:
- Shared package bascomp_pkg holds:
  - the state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - owner encoding (OWN_CPU = 1'b0, OWN_LDR = 1'b1);
  - ADDR_W and DATA_W defaults.
- Sub-module rr_pick2: a combinational two-way round-robin picker. Inputs are req[1:0] and last_owner; outputs are grant_valid and grant_id. last_owner itself is a register in the parent.

Test Plan:
- CPU read only: cpu_req = 1, cpu_we = 0, cpu_addr = 12'h010, memory[0x010] = 16'h7800 -> mem_read high in cycle 1 with mem_addr = 0x010; cpu_done and rdata = 16'h7800 in cycle 2; ldr_done stays 0.
- Loader write then CPU read: loader writes 16'hA5A5 to 12'h0FF, then the CPU reads 12'h0FF -> rdata = 16'hA5A5; each access takes exactly 3 cycles.
- Simultaneous requests after reset: both req in the same cycle -> CPU served first (done at cycle 2), loader served next (done at cycle 5); repeated ties alternate CPU, LDR, CPU.
- Reset during ACCESS of a CPU read -> no cpu_done; state IDLE; all strobes 0 the next cycle; a fresh request completes normally.
- MEM_ARBITER_LOCK_EN: loader issues 4 locked writes to 0x000–0x003 while cpu_req is held high -> all 4 ldr_done pulses arrive before cpu_done; locked = 1 throughout; the CPU is served after ldr_lock drops.
- Without the macro, the same stimulus -> grants interleave LDR, CPU, LDR, ...; locked is always 0.
